ahb_lite_s: RTL

AHB-Lite subordinate (slave) with an internal word-addressed memory, programmable wait states and two-cycle ERROR responses. It is the responder at the other end of the bus driven by our AHB-Lite master (`ahb_lite_m`), and it serves as both the bench target and the on-chip scratch RAM. The block samples address phases, runs pipelined data phases, and applies byte-lane writes and reads.

---
 rtl/ahb_lite_s.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ahb_lite_s.sv
// AHB-Lite subordinate with an internal word-addressed RAM.
// It inserts programmable wait states on OKAY transfers.
// Misaligned, oversized or out-of-range transfers get a two-cycle ERROR response.
module ahb_lite_s #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned WAIT       = 0
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HBURST,
    input  logic [3:0]    HPROT,
    input  logic          HMASTLOCK,
    input  logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    output logic [DW-1:0] HRDATA,
    output logic          HREADYOUT,
    output logic          HRESP
);

    // Byte-address bits that land inside the array
    localparam int unsigned LW = DEPTH_LOG2 + 2;
    localparam logic [3:0] WcntInit = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [2:0] {StIdle, StDwait, StData, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [LW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;

    logic          accept;
    logic          xfer_err;
    logic [3:0]    byte_en;
    logic [DW-1:0] mem [(1 << DEPTH_LOG2)];

    // Burst/protection/lock qualifiers do not affect this target
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];

    // Classify the address phase being presented
    always_comb begin
        xfer_err = 1'b0;
        if (HSIZE > 3'd2) xfer_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0]) xfer_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) xfer_err = 1'b1;
        if ((HADDR >> LW) != '0) xfer_err = 1'b1;
    end

    // Next-state, transfer capture and response outputs
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            StIdle, StData, StErr2: begin
                if (state_q == StErr2) HRESP = 1'b1;
                if (accept) begin
                    addr_d  = HADDR[LW-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (xfer_err) begin
                        state_d = StErr1;
                    end else if (WAIT == 0) begin
                        state_d = StData;
                    end else begin
                        state_d = StDwait;
                        wcnt_d  = WcntInit;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StDwait: begin
                HREADYOUT = 1'b0;
                if (wcnt_q == 4'd0) state_d = StData;
                else wcnt_d = wcnt_q - 4'd1;
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured address-phase registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Little-endian lane enables for the transfer in its data phase
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en[addr_q[1:0]] = 1'b1;
            2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Commit write lanes at the end of the DATA cycle; array is never reset
    always_ff @(posedge HCLK) begin
        if (state_q == StData && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[addr_q[LW-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Full word returned only in a read DATA cycle
    always_comb begin
        HRDATA = '0;
        if (state_q == StData && !write_q) HRDATA = mem[addr_q[LW-1:2]];
    end

endmodule
